// File: rtl/gc_flush_sequencer.sv
// Global-control flush sequencer: arbitrates channel requests, exceptions and interrupts, then drains,
// flushes, optionally clears TLBs and discards the post-issue pipeline. Optional watchdog: GC_DRAIN_TIMEOUT_EN.
module gc_flush_sequencer #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CNT_W           = 7,
  parameter int unsigned CLEAR_DEPTH     = 64,
  parameter int unsigned INT_WAIT_CYCLES = 2,
  parameter int unsigned DRAIN_TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH-1:0]    req_drain,
  input  logic [NUM_CH-1:0]    req_clear,
  input  logic [NUM_CH*32-1:0] req_pc,
  output logic [NUM_CH-1:0]    req_ack,
  input  logic                 exception_valid,
  input  logic [31:0]          exception_target_pc,
  input  logic                 interrupt_pending,
  output logic                 interrupt_taken,
  input  logic [CNT_W-1:0]     post_issue_count,
  input  logic                 sq_empty,
  input  logic                 no_released_stores_pending,
  output logic                 fetch_hold,
  output logic                 issue_hold,
  output logic                 retire_hold,
  output logic                 writeback_supress,
  output logic                 tlb_flush,
  output logic                 sq_flush,
  output logic                 pc_override,
  output logic [31:0]          pc,
  output logic                 drain_timeout
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MAX_CI  = (CLEAR_DEPTH > INT_WAIT_CYCLES) ? CLEAR_DEPTH : INT_WAIT_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_CI > DRAIN_TIMEOUT) ? MAX_CI : DRAIN_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    S_RESET, S_INIT_CLEAR, S_IDLE, S_INT_WAIT, S_DRAIN, S_FLUSH, S_CLEAR, S_DISCARD
  } state_e;

  typedef enum logic [1:0] {SRC_NONE, SRC_EXC, SRC_INT, SRC_CH} src_e;

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [IDX_W-1:0]   ch_q, ch_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;

  logic [NUM_CH-1:0]  req_ack_q, req_ack_d;
  logic               interrupt_taken_q, interrupt_taken_d;
  logic               fetch_hold_q, fetch_hold_d;
  logic               issue_hold_q, issue_hold_d;
  logic               retire_hold_q, retire_hold_d;
  logic               writeback_supress_q, writeback_supress_d;
  logic               tlb_flush_q, tlb_flush_d;
  logic               sq_flush_q, sq_flush_d;
  logic               pc_override_q, pc_override_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               drain_timeout_q, drain_timeout_d;

  logic               req_any;
  logic [IDX_W-1:0]   req_idx;
  logic               post_idle;
  logic               timeout_fire;

  // Lowest-index pending channel wins
  always_comb begin
    req_any = |req_valid;
    req_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req_valid[i]) req_idx = IDX_W'(i);
    end
  end

  assign post_idle = (post_issue_count == '0) && sq_empty;

  // Next-state, source latch and registered output decode
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    ch_d         = ch_q;
    timeout_fire = 1'b0;

    unique case (state_q)
      S_RESET:      state_d = S_INIT_CLEAR;
      S_INIT_CLEAR: if (tmr_q == TMR_W'(CLEAR_DEPTH - 1)) state_d = S_IDLE;
      S_IDLE: begin
        if (exception_valid) begin
          state_d = S_FLUSH;
          src_d   = SRC_EXC;
        end else if (req_any) begin
          ch_d    = req_idx;
          src_d   = SRC_CH;
          state_d = req_drain[req_idx] ? S_DRAIN : S_FLUSH;
        end else if (interrupt_pending) begin
          state_d = S_INT_WAIT;
        end
      end
      S_INT_WAIT: begin
        if (exception_valid) begin
          state_d = S_FLUSH;
          src_d   = SRC_EXC;
        end else if (req_any || !interrupt_pending) begin
          state_d = S_IDLE;
        end else if (tmr_q == TMR_W'(INT_WAIT_CYCLES - 1)) begin
          state_d = S_DRAIN;
          src_d   = SRC_INT;
        end
      end
      S_DRAIN: begin
        // An exception pre-empts the drain; a pending channel is retried from IDLE later
        if (exception_valid) begin
          state_d = S_FLUSH;
          src_d   = SRC_EXC;
        end else if ((src_q == SRC_INT) && !interrupt_pending) begin
          state_d = S_IDLE;
        end else if (post_idle) begin
          state_d = S_FLUSH;
        end
`ifdef GC_DRAIN_TIMEOUT_EN
        else if (tmr_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
          state_d      = S_FLUSH;
          timeout_fire = 1'b1;
        end
`endif
      end
      S_FLUSH:   state_d = ((src_q == SRC_CH) && req_clear[ch_q]) ? S_CLEAR : S_DISCARD;
      S_CLEAR:   if (tmr_q == TMR_W'(CLEAR_DEPTH - 1)) state_d = S_DISCARD;
      S_DISCARD: if ((post_issue_count == '0) && no_released_stores_pending) state_d = S_IDLE;
      default:   state_d = S_RESET;
    endcase

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) src_d = SRC_NONE;

    tmr_d = (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);

    pc_d = pc_q;
    if (state_d == S_FLUSH) begin
      pc_d = (src_d == SRC_CH) ? req_pc[PC_W*ch_d +: PC_W] : exception_target_pc;
    end

    fetch_hold_d        = (state_d == S_INIT_CLEAR) || (state_d == S_DRAIN) ||
                          (state_d == S_FLUSH) || (state_d == S_CLEAR);
    issue_hold_d        = (state_d != S_IDLE);
    retire_hold_d       = (state_d == S_FLUSH);
    pc_override_d       = (state_d == S_FLUSH);
    writeback_supress_d = (state_d == S_INIT_CLEAR) || (state_d == S_DISCARD);
    tlb_flush_d         = (state_d == S_INIT_CLEAR) || (state_d == S_CLEAR);
    sq_flush_d          = (state_q == S_DISCARD) && (state_d == S_IDLE);
    req_ack_d           = ((state_d == S_FLUSH) && (src_d == SRC_CH)) ? (NUM_CH'(1) << ch_d) : '0;
    interrupt_taken_d   = (state_d == S_FLUSH) && (src_d == SRC_INT);
    drain_timeout_d     = timeout_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q             <= S_RESET;
      src_q               <= SRC_NONE;
      ch_q                <= '0;
      tmr_q               <= '0;
      req_ack_q           <= '0;
      interrupt_taken_q   <= 1'b0;
      fetch_hold_q        <= 1'b0;
      issue_hold_q        <= 1'b0;
      retire_hold_q       <= 1'b0;
      writeback_supress_q <= 1'b0;
      tlb_flush_q         <= 1'b0;
      sq_flush_q          <= 1'b0;
      pc_override_q       <= 1'b0;
      pc_q                <= '0;
      drain_timeout_q     <= 1'b0;
    end else begin
      state_q             <= state_d;
      src_q               <= src_d;
      ch_q                <= ch_d;
      tmr_q               <= tmr_d;
      req_ack_q           <= req_ack_d;
      interrupt_taken_q   <= interrupt_taken_d;
      fetch_hold_q        <= fetch_hold_d;
      issue_hold_q        <= issue_hold_d;
      retire_hold_q       <= retire_hold_d;
      writeback_supress_q <= writeback_supress_d;
      tlb_flush_q         <= tlb_flush_d;
      sq_flush_q          <= sq_flush_d;
      pc_override_q       <= pc_override_d;
      pc_q                <= pc_d;
      drain_timeout_q     <= drain_timeout_d;
    end
  end

  assign req_ack           = req_ack_q;
  assign interrupt_taken   = interrupt_taken_q;
  assign fetch_hold        = fetch_hold_q;
  assign issue_hold        = issue_hold_q;
  assign retire_hold       = retire_hold_q;
  assign writeback_supress = writeback_supress_q;
  assign tlb_flush         = tlb_flush_q;
  assign sq_flush          = sq_flush_q;
  assign pc_override       = pc_override_q;
  assign pc                = pc_q;
  assign drain_timeout     = drain_timeout_q;

endmodule
